id_ex_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage NPC core. Captures decoded instruction and operands from ID and presents them to EX.
- Supplies ex_rs1/ex_rs2/ex_rd/ex_is_load to the data-hazard controller and consumes its if_id_stall to insert load-use bubbles.
- Also handles branch-redirect flush, the valid/ready handshake on both sides, and register-file write-through from WB.

---
 rtl/id_ex_reg_pkg.sv | 29 ++
 rtl/id_ex_reg_operand_wt_bypass.sv | 18 +
 rtl/id_ex_reg.sv | 145 ++++++++++++++
 tb/tb_id_ex_reg.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared core definitions for the NPC pipeline registers: widths, the ID/EX
// payload layout and the write-through match rule.
package id_ex_reg_pkg;

  localparam int CORE_XLEN = 64;
  localparam int REG_IDX_W = 5;
  localparam int INST_W    = 32;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [INST_W-1:0]    inst;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_w_en;
    logic                 is_load;
    logic [CORE_XLEN-1:0] src1;
    logic [CORE_XLEN-1:0] src2;
    logic [CORE_XLEN-1:0] imm;
  } id_ex_payload_t;

  // x0 is hardwired to zero, so a WB write to it must never be forwarded.
  function automatic logic wt_hit(input logic                 wb_en,
                                  input logic [REG_IDX_W-1:0] wb_rd,
                                  input logic [REG_IDX_W-1:0] rs);
    return wb_en && (wb_rd != '0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_reg_operand_wt_bypass.sv
// Register-file write-through for one source operand: picks the WB value when
// WB is writing the register this operand was read from in the same cycle.
module operand_wt_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic                 wb_rd_w_en_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_rd_data_i,
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [XLEN-1:0]      src_i,
  output logic [XLEN-1:0]      src_o
);

  assign src_o = wt_hit(wb_rd_w_en_i, wb_rd_i, rs_i) ? wb_rd_data_i : src_i;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: valid/ready handshake, load-use bubble insertion,
// branch flush and WB write-through into the captured operands.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [INST_W-1:0]    id_inst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rd_w_en,
  input  logic                 id_is_load,
  input  logic [XLEN-1:0]      id_src1,
  input  logic [XLEN-1:0]      id_src2,
  input  logic [XLEN-1:0]      id_imm,
  input  logic                 if_id_stall,
  input  logic                 ex_flush,
  input  logic                 wb_rd_w_en,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_rd_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_pc,
  output logic [INST_W-1:0]    ex_inst,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_rd_w_en,
  output logic                 ex_is_load,
  output logic [XLEN-1:0]      ex_src1,
  output logic [XLEN-1:0]      ex_src2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [INST_W-1:0]    inst_q, inst_d;
  logic [REG_IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                 rd_w_en_q, rd_w_en_d, is_load_q, is_load_d;
  logic [XLEN-1:0]      src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
  logic [CNT_W-1:0]     bcnt_q, bcnt_d;
  logic [XLEN-1:0]      wt_src1, wt_src2;
  logic                 advance;

  assign advance  = ~valid_q | ex_ready;
  assign id_ready = ex_flush | (advance & ~if_id_stall);

  operand_wt_bypass #(.XLEN(XLEN)) u_wt_src1 (
    .wb_rd_w_en_i(wb_rd_w_en), .wb_rd_i(wb_rd), .wb_rd_data_i(wb_rd_data),
    .rs_i(id_rs1), .src_i(id_src1), .src_o(wt_src1)
  );

  operand_wt_bypass #(.XLEN(XLEN)) u_wt_src2 (
    .wb_rd_w_en_i(wb_rd_w_en), .wb_rd_i(wb_rd), .wb_rd_data_i(wb_rd_data),
    .rs_i(id_rs2), .src_i(id_src2), .src_o(wt_src2)
  );

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rd_w_en_d = rd_w_en_q;
    is_load_d = is_load_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    bcnt_d    = bcnt_q;
    // Empty slots always carry rd=0 so hazard/forward compares never match.
    if (ex_flush || (advance && (if_id_stall || !id_valid))) begin
      valid_d   = 1'b0;
      rd_d      = '0;
      rd_w_en_d = 1'b0;
      is_load_d = 1'b0;
      if (!ex_flush && if_id_stall && (bcnt_q != '1))
        bcnt_d = bcnt_q + CNT_W'(1);
    end else if (advance) begin
      valid_d   = 1'b1;
      pc_d      = id_pc;
      inst_d    = id_inst;
      rs1_d     = id_rs1;
      rs2_d     = id_rs2;
      rd_d      = id_rd;
      rd_w_en_d = id_rd_w_en;
      is_load_d = id_is_load;
      src1_d    = wt_src1;
      src2_d    = wt_src2;
      imm_d     = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rd_w_en_q <= 1'b0;
      is_load_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      bcnt_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rd_w_en_q <= rd_w_en_d;
      is_load_q <= is_load_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_inst    = inst_q;
  assign ex_rs1     = rs1_q;
  assign ex_rs2     = rs2_q;
  assign ex_rd      = rd_q;
  assign ex_rd_w_en = rd_w_en_q;
  assign ex_is_load = is_load_q;
  assign ex_src1    = src1_q;
  assign ex_src2    = src2_q;
  assign ex_imm     = imm_q;
  assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus a randomized run against a
// cycle-level reference model of the stage.
module tb_id_ex_reg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_ready, id_rd_w_en, id_is_load, if_id_stall, ex_flush;
  logic [XLEN-1:0] id_pc, id_src1, id_src2, id_imm, wb_rd_data;
  logic [31:0] id_inst;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic wb_rd_w_en, ex_valid, ex_ready, ex_rd_w_en, ex_is_load;
  logic [XLEN-1:0] ex_pc, ex_src1, ex_src2, ex_imm;
  logic [31:0] ex_inst;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic m_valid, m_w, m_load;
  logic [XLEN-1:0] m_pc, m_s1, m_s2, m_imm;
  logic [31:0] m_inst;
  logic [4:0] m_rs1, m_rs2, m_rd;
  int m_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd_w_en(id_rd_w_en), .id_is_load(id_is_load),
    .id_src1(id_src1), .id_src2(id_src2), .id_imm(id_imm),
    .if_id_stall(if_id_stall), .ex_flush(ex_flush), .wb_rd_w_en(wb_rd_w_en),
    .wb_rd(wb_rd), .wb_rd_data(wb_rd_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_w_en(ex_rd_w_en),
    .ex_is_load(ex_is_load), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
  );

  task automatic clear_inputs();
    id_valid = 0; id_pc = '0; id_inst = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd_w_en = 0; id_is_load = 0; id_src1 = '0; id_src2 = '0; id_imm = '0;
    if_id_stall = 0; ex_flush = 0; wb_rd_w_en = 0; wb_rd = '0; wb_rd_data = '0;
    ex_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: one clock edge of the stage, expressed as the stage's rules.
  task automatic model_edge();
    logic adv;
    adv = !m_valid || ex_ready;
    if (ex_flush) begin
      m_valid = 0; m_rd = 0; m_w = 0; m_load = 0;
    end else if (!adv) begin
      // back-pressure: nothing moves
    end else if (if_id_stall) begin
      m_valid = 0; m_rd = 0; m_w = 0; m_load = 0;
      if (m_cnt < CMAX) m_cnt++;
    end else if (id_valid) begin
      m_valid = 1; m_pc = id_pc; m_inst = id_inst; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_rd = id_rd; m_w = id_rd_w_en; m_load = id_is_load; m_imm = id_imm;
      m_s1 = (wb_rd_w_en && wb_rd != 0 && wb_rd == id_rs1) ? wb_rd_data : id_src1;
      m_s2 = (wb_rd_w_en && wb_rd != 0 && wb_rd == id_rs2) ? wb_rd_data : id_src2;
    end else begin
      m_valid = 0; m_rd = 0; m_w = 0; m_load = 0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    m_valid = 0; m_w = 0; m_load = 0; m_pc = '0; m_s1 = '0; m_s2 = '0; m_imm = '0;
    m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_cnt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({ex_valid, ex_rd, ex_rd_w_en, ex_is_load, bubble_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%0b rd=%0d w=%0b ld=%0b cnt=%0d, want all 0",
               ex_valid, ex_rd, ex_rd_w_en, ex_is_load, bubble_cnt);
    end
    checks++;
    if ({ex_pc, ex_inst, ex_src1, ex_src2, ex_imm, ex_rs1, ex_rs2} !== '0) begin
      failures++;
      $display("FAIL reset_payload: got pc=%h src1=%h, want 0", ex_pc, ex_src1);
    end
    rst_n = 1;
  endtask

  task automatic test_pass_through();
    clear_inputs();
    id_valid = 1; id_pc = 64'h8000_0000; id_rd = 5; ex_ready = 1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++; $display("FAIL pt_id_ready: got %0b want 1", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h8000_0000 || ex_rd !== 5'd5) begin
      failures++;
      $display("FAIL pt_capture: got v=%0b pc=%h rd=%0d want 1 80000000 5", ex_valid, ex_pc, ex_rd);
    end
    id_pc = 64'h8000_0004; id_rd = 6;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++; $display("FAIL pt_id_ready2: got %0b want 1", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h8000_0004 || ex_rd !== 5'd6) begin
      failures++;
      $display("FAIL pt_b2b: got v=%0b pc=%h rd=%0d want 1 80000004 6", ex_valid, ex_pc, ex_rd);
    end
  endtask

  task automatic test_load_use();
    id_valid = 1; id_pc = 64'h100; id_rd = 9; id_rd_w_en = 1; ex_ready = 1; if_id_stall = 1;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      failures++; $display("FAIL lu_id_ready: got %0b want 0", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_rd_w_en !== 1'b0 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL lu_bubble: got v=%0b rd=%0d w=%0b cnt=%0d want 0 0 0 1",
               ex_valid, ex_rd, ex_rd_w_en, bubble_cnt);
    end
    if_id_stall = 0;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_pc !== 64'h100 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL lu_resume: got v=%0b rd=%0d pc=%h cnt=%0d want 1 9 100 1",
               ex_valid, ex_rd, ex_pc, bubble_cnt);
    end
  endtask

  task automatic test_back_pressure();
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      id_pc = 64'h200 + 64'(i * 4); id_rd = 5'(10 + i);
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
        failures++; $display("FAIL bp_id_ready[%0d]: got %0b want 0", i, id_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 64'h100 || ex_rd !== 5'd9) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%0b pc=%h rd=%0d want 1 100 9", i, ex_valid, ex_pc, ex_rd);
      end
    end
    ex_ready = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h208 || ex_rd !== 5'd12) begin
      failures++;
      $display("FAIL bp_release: got v=%0b pc=%h rd=%0d want 1 208 12", ex_valid, ex_pc, ex_rd);
    end
  endtask

  task automatic test_flush();
    ex_flush = 1; ex_ready = 0; if_id_stall = 1; id_valid = 1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++; $display("FAIL fl_id_ready: got %0b want 1", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd_w_en !== 1'b0 || ex_rd !== 5'd0 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL fl_result: got v=%0b w=%0b rd=%0d cnt=%0d want 0 0 0 1",
               ex_valid, ex_rd_w_en, ex_rd, bubble_cnt);
    end
    ex_flush = 0; if_id_stall = 0; ex_ready = 1;
  endtask

  task automatic test_write_through();
    id_valid = 1; wb_rd_w_en = 1; wb_rd = 7; wb_rd_data = 64'hDEAD;
    id_rs1 = 7; id_rs2 = 0; id_src1 = 64'h1111; id_src2 = 64'h1;
    tick();
    checks++;
    if (ex_src1 !== 64'hDEAD || ex_src2 !== 64'h1) begin
      failures++;
      $display("FAIL wt_hit: got src1=%h src2=%h want dead 1", ex_src1, ex_src2);
    end
    wb_rd = 0; id_rs1 = 0; id_src1 = 64'h2222;
    tick();
    checks++;
    if (ex_src1 !== 64'h2222 || ex_src2 !== 64'h1) begin
      failures++;
      $display("FAIL wt_x0: got src1=%h src2=%h want 2222 1", ex_src1, ex_src2);
    end
  endtask

  task automatic test_async_reset();
    checks++;
    if (ex_valid !== 1'b1 || bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL ar_pre: got v=%0b cnt=%0d want 1 1", ex_valid, bubble_cnt);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || bubble_cnt !== '0 || ex_src1 !== '0) begin
      failures++;
      $display("FAIL ar_clear: got v=%0b rd=%0d cnt=%0d src1=%h want all 0",
               ex_valid, ex_rd, bubble_cnt, ex_src1);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    logic exp_ready;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_pc       = {$urandom, $urandom};
      id_inst     = $urandom;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 31));
      id_rd_w_en  = 1'($urandom);
      id_is_load  = 1'($urandom);
      id_src1     = {$urandom, $urandom};
      id_src2     = {$urandom, $urandom};
      id_imm      = {$urandom, $urandom};
      if_id_stall = ($urandom_range(0, 3) == 0);
      ex_flush    = ($urandom_range(0, 9) == 0);
      ex_ready    = ($urandom_range(0, 9) < 7);
      wb_rd_w_en  = 1'($urandom);
      wb_rd       = 5'($urandom_range(0, 3));
      wb_rd_data  = {$urandom, $urandom};
      #1;
      exp_ready = ex_flush || ((!m_valid || ex_ready) && !if_id_stall);
      checks++;
      if (id_ready !== exp_ready) begin
        failures++; $display("FAIL rnd_id_ready[%0d]: got %0b want %0b", c, id_ready, exp_ready);
      end
      model_edge();
      tick();
      checks++;
      if (ex_valid !== m_valid || ex_rd !== m_rd || ex_rd_w_en !== m_w ||
          ex_is_load !== m_load || int'(bubble_cnt) != m_cnt) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d]: got v=%0b rd=%0d w=%0b ld=%0b cnt=%0d want %0b %0d %0b %0b %0d",
                 c, ex_valid, ex_rd, ex_rd_w_en, ex_is_load, bubble_cnt,
                 m_valid, m_rd, m_w, m_load, m_cnt);
      end
      if (m_valid) begin
        checks++;
        if (ex_pc !== m_pc || ex_inst !== m_inst || ex_rs1 !== m_rs1 || ex_rs2 !== m_rs2 ||
            ex_src1 !== m_s1 || ex_src2 !== m_s2 || ex_imm !== m_imm) begin
          failures++;
          $display("FAIL rnd_payload[%0d]: got pc=%h src1=%h src2=%h want pc=%h src1=%h src2=%h",
                   c, ex_pc, ex_src1, ex_src2, m_pc, m_s1, m_s2);
        end
      end
    end
    checks++;
    if (int'(bubble_cnt) != CMAX) begin
      failures++; $display("FAIL rnd_saturate: got cnt=%0d want %0d", bubble_cnt, CMAX);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_write_through();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
